fir_reload_ctrl: RTL and testbench

Sequencer for the FIR filter core's coefficient reload and config AXI-Stream ports in the fir129 RFNoC block. The host writes a full coefficient set into a local shadow RAM over the settings bus and then issues a commit. The block then streams the set in tap order on the reload bus, asserting tlast on the final tap. After the last tap is accepted it sends one config word so that the core switches to the new coefficients. Status outputs report busy state, completed reloads and protocol errors to the readback mux.

---
 rtl/fir_reload_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fir_reload_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_reload_ctrl.sv
// Coefficient reload sequencer for the fir129 FIR core: shadow RAM, tap streaming, config word.
// Optional build macro FIR_RELOAD_CHECKSUM_EN adds a running checksum of each streamed set.
module fir_reload_ctrl #(
    parameter int          NUM_TAPS      = 129,
    parameter int          COEFF_WIDTH   = 16,
    parameter logic [7:0]  SR_COEFF_IDX  = 8'd128,
    parameter logic [7:0]  SR_COEFF_DATA = 8'd129,
    parameter logic [7:0]  SR_COMMIT     = 8'd130
) (
    input  logic                   ce_clk,
    input  logic                   ce_rst_n,
    input  logic                   set_stb,
    input  logic [7:0]             set_addr,
    input  logic [31:0]            set_data,
    output logic [COEFF_WIDTH-1:0] o_reload_tdata,
    output logic                   o_reload_tlast,
    output logic                   o_reload_tvalid,
    input  logic                   o_reload_tready,
    output logic [7:0]             o_config_tdata,
    output logic                   o_config_tvalid,
    input  logic                   o_config_tready,
    output logic                   busy,
    output logic [15:0]            reload_count,
    output logic [1:0]             err,
    output logic [31:0]            checksum
);

    // state  | meaning
    // IDLE   | accepting coefficient writes, waiting for commit
    // PRIME  | RAM read latency for tap 0
    // STREAM | presenting taps on the reload bus
    // CONFIG | presenting the config word

    localparam int         AW       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [7:0] LAST_TAP = 8'(NUM_TAPS - 1);
    localparam logic [8:0] TAP_CNT  = 9'(NUM_TAPS);
    localparam logic [7:0] SR_CLEAR = SR_COMMIT + 8'd1;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, CONFIG} state_t;
    state_t state_q, state_d;

    logic [COEFF_WIDTH-1:0] ram [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] rd_data_q;
    logic [7:0]             wr_idx_q;
    logic [7:0]             tap_idx_q;
    logic [7:0]             cfg_word_q;
    logic [15:0]            count_q;
    logic [1:0]             err_q, err_d;

    logic       idx_stb, data_stb, commit_stb, clear_stb;
    logic       idle, reload_hs, config_hs, last_tap;
    logic       rd_en, wr_en;
    logic [7:0] rd_addr;
    logic       unused_bits;

    assign idx_stb    = set_stb && (set_addr == SR_COEFF_IDX);
    assign data_stb   = set_stb && (set_addr == SR_COEFF_DATA);
    assign commit_stb = set_stb && (set_addr == SR_COMMIT);
    assign clear_stb  = set_stb && (set_addr == SR_CLEAR);

    assign idle      = (state_q == IDLE);
    assign last_tap  = (tap_idx_q == LAST_TAP);
    assign reload_hs = (state_q == STREAM) && o_reload_tready;
    assign config_hs = (state_q == CONFIG) && o_config_tready;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        o_reload_tvalid = 1'b0;
        o_reload_tlast  = 1'b0;
        o_config_tvalid = 1'b0;
        busy            = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (commit_stb) state_d = PRIME;
            end
            PRIME: state_d = STREAM;
            STREAM: begin
                o_reload_tvalid = 1'b1;
                o_reload_tlast  = last_tap;
                if (reload_hs && last_tap) state_d = CONFIG;
            end
            CONFIG: begin
                o_config_tvalid = 1'b1;
                if (config_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read one tap ahead on each accepted beat so streaming has no bubbles;
    // otherwise rd_data_q holds, which keeps tdata stable under backpressure.
    assign rd_en   = (state_q == PRIME) || (reload_hs && !last_tap);
    assign rd_addr = (state_q == PRIME) ? 8'd0 : tap_idx_q + 8'd1;
    assign wr_en   = idle && data_stb && ({1'b0, wr_idx_q} < TAP_CNT);

    always_ff @(posedge ce_clk) begin
        if (wr_en) ram[wr_idx_q[AW-1:0]] <= set_data[COEFF_WIDTH-1:0];
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n)  rd_data_q <= '0;
        else if (rd_en) rd_data_q <= ram[rd_addr[AW-1:0]];
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            wr_idx_q <= '0;
        end else if (idle && idx_stb) begin
            wr_idx_q <= set_data[7:0];
        end else if (idle && data_stb) begin
            wr_idx_q <= (wr_idx_q == LAST_TAP) ? 8'd0 : wr_idx_q + 8'd1;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            tap_idx_q  <= '0;
            cfg_word_q <= '0;
        end else if (idle && commit_stb) begin
            tap_idx_q  <= '0;
            cfg_word_q <= set_data[7:0];
        end else if (reload_hs && !last_tap) begin
            tap_idx_q  <= tap_idx_q + 8'd1;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n)      count_q <= '0;
        else if (config_hs) count_q <= count_q + 16'd1;
    end

    // Clear first, then set, so a new error in the clearing cycle survives.
    always_comb begin
        err_d = clear_stb ? 2'b00 : err_q;
        if (!idle && (idx_stb || data_stb)) err_d[0] = 1'b1;
        if (!idle && commit_stb)            err_d[1] = 1'b1;
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) err_q <= '0;
        else           err_q <= err_d;
    end

`ifdef FIR_RELOAD_CHECKSUM_EN
    logic [31:0] acc_q, checksum_q, tap_sext;
    assign tap_sext = 32'($signed(rd_data_q));

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            if (idle && commit_stb) acc_q <= '0;
            else if (reload_hs)     acc_q <= acc_q + tap_sext;
            if (config_hs)          checksum_q <= acc_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign o_reload_tdata = rd_data_q;
    assign o_config_tdata = cfg_word_q;
    assign reload_count   = count_q;
    assign err            = err_q;
    assign unused_bits    = ^{set_data, rd_addr};

endmodule

// File: tb/tb_fir_reload_ctrl.sv
// Scoreboard bench for fir_reload_ctrl: stimulus queues expected beats/config words, a monitor checks them.
module tb_fir_reload_ctrl;
    localparam int N  = 129;
    localparam int CW = 16;
    localparam logic [7:0] A_IDX = 8'd128, A_DATA = 8'd129, A_COMMIT = 8'd130, A_CLEAR = 8'd131;

    logic          ce_clk = 1'b0;
    logic          ce_rst_n = 1'b0;
    logic          set_stb = 1'b0;
    logic [7:0]    set_addr = '0;
    logic [31:0]   set_data = '0;
    logic [CW-1:0] o_reload_tdata;
    logic          o_reload_tlast, o_reload_tvalid;
    logic          o_reload_tready = 1'b1;
    logic [7:0]    o_config_tdata;
    logic          o_config_tvalid;
    logic          o_config_tready = 1'b1;
    logic          busy;
    logic [15:0]   reload_count;
    logic [1:0]    err;
    logic [31:0]   checksum;

    fir_reload_ctrl dut (
        .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .o_reload_tdata(o_reload_tdata), .o_reload_tlast(o_reload_tlast),
        .o_reload_tvalid(o_reload_tvalid), .o_reload_tready(o_reload_tready),
        .o_config_tdata(o_config_tdata), .o_config_tvalid(o_config_tvalid),
        .o_config_tready(o_config_tready),
        .busy(busy), .reload_count(reload_count), .err(err), .checksum(checksum)
    );

    always #5 ce_clk = ~ce_clk;

    int cyc = 0;
    always @(posedge ce_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int beats_seen = 0;
    bit rand_ready = 1'b0;
    logic [16:0]   exp_beats[$];
    logic [7:0]    exp_cfg[$];
    logic [CW-1:0] model[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_checksum();
        logic [31:0] s = '0;
`ifdef FIR_RELOAD_CHECKSUM_EN
        for (int i = 0; i < N; i++) s = s + 32'($signed(model[i]));
`endif
        return s;
    endfunction

    task automatic sw(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge ce_clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic load_model();
        sw(A_IDX, 32'd0);
        for (int i = 0; i < N; i++) sw(A_DATA, 32'(model[i]));
    endtask

    task automatic push_set(input logic [7:0] cfg);
        for (int i = 0; i < N; i++) exp_beats.push_back({(i == N - 1), model[i]});
        exp_cfg.push_back(cfg);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge ce_clk);
            if (!busy) break;
        end
        if (k == budget) begin
            n_checks++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
        end
        @(posedge ce_clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge ce_clk); #1;
            o_reload_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations on handshakes and checks AXI hold-while-stalled.
    initial begin
        bit          r_stall = 1'b0, c_stall = 1'b0;
        logic [16:0] r_held;
        logic [7:0]  c_held;
        logic [16:0] e;
        logic [7:0]  ec;
        forever begin
            @(negedge ce_clk);
            if (!ce_rst_n) begin
                r_stall = 1'b0;
                c_stall = 1'b0;
            end else begin
                if (r_stall) begin
                    chk("reload_valid_held", o_reload_tvalid, 1'b1);
                    chk("reload_beat_stable", {o_reload_tlast, o_reload_tdata}, r_held);
                end
                if (c_stall) begin
                    chk("config_valid_held", o_config_tvalid, 1'b1);
                    chk("config_word_stable", o_config_tdata, c_held);
                end
                if (o_reload_tvalid && o_reload_tready) begin
                    if (exp_beats.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got beat 0x%0h, expected none", {o_reload_tlast, o_reload_tdata});
                    end else begin
                        e = exp_beats.pop_front();
                        chk("reload_beat", {o_reload_tlast, o_reload_tdata}, e);
                    end
                    beats_seen++;
                end
                if (o_config_tvalid && o_config_tready) begin
                    if (exp_cfg.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_config: got 0x%0h, expected none", o_config_tdata);
                    end else begin
                        ec = exp_cfg.pop_front();
                        chk("config_word", o_config_tdata, ec);
                    end
                end
                r_stall = o_reload_tvalid && !o_reload_tready;
                r_held  = {o_reload_tlast, o_reload_tdata};
                c_stall = o_config_tvalid && !o_config_tready;
                c_held  = o_config_tdata;
            end
        end
    end

    initial begin
        int c0, t, t_valid, t_cfg, t_done, b0;
        bit seen;

        // reset state
        repeat (3) @(posedge ce_clk);
        #1;
        chk("rst_tvalid", o_reload_tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", reload_count, 16'd0);
        ce_rst_n = 1'b1;
        @(posedge ce_clk); #1;

        // full reload, both readies high, timing
        for (int i = 0; i < N; i++) model[i] = 16'(i + 1);
        load_model();
        push_set(8'h00);
        c0 = cyc;
        sw(A_COMMIT, 32'h0);
        chk("busy_cycle1", busy, 1'b1);
        t_valid = -1; t_cfg = -1; t_done = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge ce_clk);
            t = cyc - c0;
            if (o_reload_tvalid && t_valid < 0) t_valid = t;
            if (o_config_tvalid && t_cfg < 0)   t_cfg = t;
            if (!busy) begin t_done = t; break; end
        end
        chk("first_beat_cycle", t_valid, 2);
        chk("config_valid_cycle", t_cfg, 131);
        chk("busy_low_cycle", t_done, 132);
        chk("count_after_1", reload_count, 16'd1);
`ifdef FIR_RELOAD_CHECKSUM_EN
        chk("checksum_1_to_129", checksum, 32'd8385);
`else
        chk("checksum_tied_off", checksum, 32'd0);
`endif
        @(posedge ce_clk); #1;

        // random reload backpressure, config ready held low 10 cycles
        rand_ready = 1'b1;
        o_config_tready = 1'b0;
        push_set(8'h5A);
        sw(A_COMMIT, 32'h5A);
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge ce_clk);
            if (o_config_tvalid) begin seen = 1'b1; break; end
        end
        chk("config_presented", seen, 1'b1);
        repeat (10) @(posedge ce_clk);
        #1;
        o_config_tready = 1'b1;
        wait_idle(50);
        rand_ready = 1'b0;
        chk("count_after_2", reload_count, 16'd2);
        chk("beats_drained_2", exp_beats.size(), 0);

        // commit while streaming is dropped and flagged
        push_set(8'h11);
        sw(A_COMMIT, 32'h11);
        repeat (10) @(posedge ce_clk);
        #1;
        sw(A_COMMIT, 32'h77);
        wait_idle(400);
        repeat (3) @(posedge ce_clk);
        #1;
        chk("err_commit_busy", err, 2'b10);
        chk("count_after_3", reload_count, 16'd3);
        chk("stray_commit_ignored", busy, 1'b0);
        sw(A_CLEAR, 32'h0);
        chk("err_cleared", err, 2'b00);

        // data write while busy is dropped; next reload streams the same set
        push_set(8'h22);
        sw(A_COMMIT, 32'h22);
        repeat (5) @(posedge ce_clk);
        #1;
        sw(A_DATA, 32'hDEAD);
        wait_idle(400);
        chk("err_write_busy", err, 2'b01);
        push_set(8'h23);
        sw(A_COMMIT, 32'h23);
        wait_idle(400);
        chk("count_after_5", reload_count, 16'd5);
        sw(A_CLEAR, 32'h0);

        // index boundaries: out-of-range write dropped, wrap at 255 and at NUM_TAPS-1
        sw(A_IDX, 32'd255);
        sw(A_DATA, 32'h7777);
        sw(A_DATA, 32'h0ABC);
        sw(A_DATA, 32'h0BCD);
        model[0] = 16'h0ABC;
        model[1] = 16'h0BCD;
        sw(A_IDX, 32'd128);
        sw(A_DATA, 32'h1234);
        sw(A_DATA, 32'h4321);
        model[128] = 16'h1234;
        model[0]   = 16'h4321;
        push_set(8'hA5);
        sw(A_COMMIT, 32'hA5);
        wait_idle(400);
        chk("count_after_6", reload_count, 16'd6);
        chk("checksum_edited_set", checksum, exp_checksum());
        chk("err_none_idle_writes", err, 2'b00);

        // asynchronous reset at tap 50
        push_set(8'h3C);
        sw(A_COMMIT, 32'h3C);
        b0 = beats_seen;
        for (int k = 0; k < 500; k++) begin
            @(posedge ce_clk);
            if (beats_seen >= b0 + 50) break;
        end
        #2;
        ce_rst_n = 1'b0;
        #1;
        chk("arst_tvalid", o_reload_tvalid, 1'b0);
        chk("arst_tlast", o_reload_tlast, 1'b0);
        chk("arst_tdata", o_reload_tdata, 16'h0);
        chk("arst_cfg_valid", o_config_tvalid, 1'b0);
        chk("arst_cfg_data", o_config_tdata, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_count", reload_count, 16'd0);
        chk("arst_err", err, 2'b00);
        chk("arst_checksum", checksum, 32'd0);
        exp_beats.delete();
        exp_cfg.delete();
        repeat (3) @(posedge ce_clk);
        #1;
        ce_rst_n = 1'b1;
        @(posedge ce_clk); #1;

        // reload without setting the index: relies on the index resetting to 0
        for (int i = 0; i < N; i++) model[i] = 16'(i * 3 + 7);
        for (int i = 0; i < N; i++) sw(A_DATA, 32'(model[i]));
        push_set(8'h00);
        sw(A_COMMIT, 32'h0);
        wait_idle(400);
        chk("count_after_reset", reload_count, 16'd1);
        chk("checksum_after_reset", checksum, exp_checksum());

        repeat (3) @(posedge ce_clk);
        #1;
        chk("beats_drained_end", exp_beats.size(), 0);
        chk("configs_drained_end", exp_cfg.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
